// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - keypad-driven H:M:S countdown timer with alarm and 1 Hz prescaler
// Optional COUNTDOWN_AUTORELOAD_EN: an alarm that times out reloads the preset and keeps running.
module countdown_ctrl #(
  parameter int CLK_HZ    = 32000000,
  parameter int ALARM_SEC = 10
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic [4:0]  key_code,
  output logic [4:0]  rem_h,
  output logic [5:0]  rem_m,
  output logic [5:0]  rem_s,
  output logic [3:0]  status,
  output logic        sec_p,
  output logic        alarm,
  output logic [15:0] bitmap
);

  localparam int PSC_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int ACNT_W = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
  localparam logic [PSC_W-1:0]  PSC_MAX  = PSC_W'(CLK_HZ - 1);
  localparam logic [ACNT_W-1:0] ACNT_MAX = ACNT_W'(ALARM_SEC - 1);

  localparam logic [4:0] KEY_MODE  = 5'd1;
  localparam logic [4:0] KEY_INC   = 5'd2;
  localparam logic [4:0] KEY_DEC   = 5'd3;
  localparam logic [4:0] KEY_START = 5'd4;
  localparam logic [4:0] KEY_CLEAR = 5'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET_H = 3'd1,
    ST_SET_M = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_ALARM = 3'd5
  } state_t;

  state_t              state, state_d;
  logic [4:0]          key_q;
  logic                ev_q;
  logic [4:0]          ev_code;
  logic [4:0]          preset_h, preset_h_d;
  logic [5:0]          preset_m, preset_m_d;
  logic [4:0]          rem_h_d;
  logic [5:0]          rem_m_d, rem_s_d;
  logic [PSC_W-1:0]    psc, psc_d;
  logic [ACNT_W-1:0]   alm_cnt, alm_cnt_d;
  logic                blink, blink_d;
  logic                sec_p_d;
  logic [15:0]         bitmap_d;

  logic k_mode, k_inc, k_dec, k_start, k_clear;
  logic tick, preset_nz, rem_last;

  // Press events are registered once more so commands land one cycle after detection.
  assign k_mode    = ev_q && (ev_code == KEY_MODE);
  assign k_inc     = ev_q && (ev_code == KEY_INC);
  assign k_dec     = ev_q && (ev_code == KEY_DEC);
  assign k_start   = ev_q && (ev_code == KEY_START);
  assign k_clear   = ev_q && (ev_code == KEY_CLEAR);
  assign tick      = (psc == PSC_MAX);
  assign preset_nz = (preset_h != 5'd0) || (preset_m != 6'd0);
  assign rem_last  = (rem_h == 5'd0) && (rem_m == 6'd0) && (rem_s == 6'd1);
  assign status    = {1'b0, state};
  assign bitmap_d  = {blink_d, 9'd0, 6'd1 << state_d};

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      key_q    <= '0;
      ev_q     <= 1'b0;
      ev_code  <= '0;
      preset_h <= '0;
      preset_m <= '0;
      rem_h    <= '0;
      rem_m    <= '0;
      rem_s    <= '0;
      psc      <= '0;
      alm_cnt  <= '0;
      blink    <= 1'b0;
      sec_p    <= 1'b0;
      alarm    <= 1'b0;
      bitmap   <= 16'h0001;
    end else begin
      state    <= state_d;
      key_q    <= key_code;
      ev_q     <= (key_q == 5'd0) && (key_code != 5'd0);
      ev_code  <= key_code;
      preset_h <= preset_h_d;
      preset_m <= preset_m_d;
      rem_h    <= rem_h_d;
      rem_m    <= rem_m_d;
      rem_s    <= rem_s_d;
      psc      <= psc_d;
      alm_cnt  <= alm_cnt_d;
      blink    <= blink_d;
      sec_p    <= sec_p_d;
      alarm    <= (state_d == ST_ALARM);
      bitmap   <= bitmap_d;
    end
  end

  always_comb begin
    state_d    = state;
    preset_h_d = preset_h;
    preset_m_d = preset_m;
    rem_h_d    = rem_h;
    rem_m_d    = rem_m;
    rem_s_d    = rem_s;
    psc_d      = '0;
    alm_cnt_d  = '0;
    blink_d    = 1'b0;
    sec_p_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (k_mode) begin
          state_d = ST_SET_H;
        end else if (k_start && preset_nz) begin
          state_d = ST_RUN;
          rem_h_d = preset_h;
          rem_m_d = preset_m;
          rem_s_d = '0;
        end else if (k_clear) begin
          preset_h_d = '0;
          preset_m_d = '0;
          rem_h_d    = '0;
          rem_m_d    = '0;
          rem_s_d    = '0;
        end
      end
      ST_SET_H: begin
        if (k_inc)      preset_h_d = (preset_h == 5'd23) ? 5'd0 : preset_h + 5'd1;
        else if (k_dec) preset_h_d = (preset_h == 5'd0) ? 5'd23 : preset_h - 5'd1;
        else if (k_mode) state_d = ST_SET_M;
        rem_h_d = preset_h_d;
        rem_m_d = preset_m_d;
        rem_s_d = '0;
      end
      ST_SET_M: begin
        if (k_inc)      preset_m_d = (preset_m == 6'd59) ? 6'd0 : preset_m + 6'd1;
        else if (k_dec) preset_m_d = (preset_m == 6'd0) ? 6'd59 : preset_m - 6'd1;
        else if (k_mode) state_d = ST_IDLE;
        rem_h_d = preset_h_d;
        rem_m_d = preset_m_d;
        rem_s_d = '0;
      end
      ST_RUN: begin
        if (k_start) begin
          state_d = ST_PAUSE;
        end else if (k_clear) begin
          state_d = ST_IDLE;
          rem_h_d = preset_h;
          rem_m_d = preset_m;
          rem_s_d = '0;
        end else begin
          psc_d = tick ? '0 : psc + PSC_W'(1);
          if (tick) begin
            sec_p_d = 1'b1;
            if (rem_s != 6'd0) begin
              rem_s_d = rem_s - 6'd1;
            end else begin
              rem_s_d = 6'd59;
              if (rem_m != 6'd0) begin
                rem_m_d = rem_m - 6'd1;
              end else begin
                rem_m_d = 6'd59;
                rem_h_d = rem_h - 5'd1;
              end
            end
            if (rem_last) begin
              state_d = ST_ALARM;
              psc_d   = '0;
              blink_d = 1'b1;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (k_start) begin
          state_d = ST_RUN;
        end else if (k_clear) begin
          state_d = ST_IDLE;
          rem_h_d = preset_h;
          rem_m_d = preset_m;
          rem_s_d = '0;
        end
      end
      ST_ALARM: begin
        // Any key at all silences the alarm, not just the command keys.
        if (ev_q) begin
          state_d = ST_IDLE;
          rem_h_d = preset_h;
          rem_m_d = preset_m;
          rem_s_d = '0;
        end else begin
          psc_d     = tick ? '0 : psc + PSC_W'(1);
          alm_cnt_d = alm_cnt;
          blink_d   = blink;
          if (tick) begin
            sec_p_d   = 1'b1;
            blink_d   = ~blink;
            alm_cnt_d = alm_cnt + ACNT_W'(1);
            if (alm_cnt == ACNT_MAX) begin
              alm_cnt_d = '0;
              blink_d   = 1'b0;
              psc_d     = '0;
              rem_h_d   = preset_h;
              rem_m_d   = preset_m;
              rem_s_d   = '0;
`ifdef COUNTDOWN_AUTORELOAD_EN
              state_d   = ST_RUN;
`else
              state_d   = ST_IDLE;
`endif
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - randomized and directed bench for countdown_ctrl against a seconds-level model
module tb_countdown_ctrl;

  localparam int CLK_HZ    = 4;
  localparam int ALARM_SEC = 3;
`ifdef COUNTDOWN_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        mclk = 1'b0;
  logic        rst_n;
  logic [4:0]  key_code;
  logic [4:0]  rem_h;
  logic [5:0]  rem_m;
  logic [5:0]  rem_s;
  logic [3:0]  status;
  logic        sec_p;
  logic        alarm;
  logic [15:0] bitmap;

  countdown_ctrl #(.CLK_HZ(CLK_HZ), .ALARM_SEC(ALARM_SEC)) dut (
    .mclk(mclk), .rst_n(rst_n), .key_code(key_code),
    .rem_h(rem_h), .rem_m(rem_m), .rem_s(rem_s), .status(status),
    .sec_p(sec_p), .alarm(alarm), .bitmap(bitmap)
  );

  always #5 mclk = ~mclk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Model: modes 0 IDLE,1 SET_H,2 SET_M,3 RUN,4 PAUSE,5 ALARM; time kept as total seconds.
  int m_mode, m_ph, m_pm, m_rem, m_el, m_alm_left, m_prev_key, m_pend_code;
  bit m_blink, m_secp, m_pend;

  function automatic int preset_secs();
    return m_ph * 3600 + m_pm * 60;
  endfunction

  function automatic logic [31:0] pack_rem(input int t);
    return 32'(((t / 3600) << 12) | (((t / 60) % 60) << 6) | (t % 60));
  endfunction

  function automatic logic [31:0] exp_flags();
    logic [15:0] bm;
    bm = 16'(1 << m_mode);
    if (m_mode == 5 && m_blink) bm[15] = 1'b1;
    return {14'd0, m_secp, (m_mode == 5), bm};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ph = 0; m_pm = 0; m_rem = 0; m_el = 0; m_alm_left = 0;
    m_prev_key = 0; m_pend_code = 0; m_blink = 0; m_secp = 0; m_pend = 0;
  endtask

  task automatic model_edge(input int k);
    bit ev;
    int c, nm;
    ev = m_pend;
    c = m_pend_code;
    m_pend = (m_prev_key == 0 && k != 0);
    m_pend_code = k;
    m_prev_key = k;
    m_secp = 0;
    nm = m_mode;
    if (!ev) c = 0;
    case (m_mode)
      0: begin
        if (c == 1) nm = 1;
        else if (c == 4 && preset_secs() > 0) begin nm = 3; m_rem = preset_secs(); end
        else if (c == 5) begin m_ph = 0; m_pm = 0; m_rem = 0; end
      end
      1: begin
        if (c == 2) m_ph = (m_ph + 1) % 24;
        else if (c == 3) m_ph = (m_ph + 23) % 24;
        else if (c == 1) nm = 2;
        m_rem = preset_secs();
      end
      2: begin
        if (c == 2) m_pm = (m_pm + 1) % 60;
        else if (c == 3) m_pm = (m_pm + 59) % 60;
        else if (c == 1) nm = 0;
        m_rem = preset_secs();
      end
      3: begin
        if (c == 4) nm = 4;
        else if (c == 5) begin nm = 0; m_rem = preset_secs(); end
        else begin
          m_el++;
          if (m_el == CLK_HZ) begin
            m_el = 0;
            m_secp = 1;
            m_rem--;
            if (m_rem == 0) begin nm = 5; m_alm_left = ALARM_SEC; m_blink = 1; end
          end
        end
      end
      4: begin
        if (c == 4) nm = 3;
        else if (c == 5) begin nm = 0; m_rem = preset_secs(); end
      end
      5: begin
        if (c >= 1 && c <= 16) begin nm = 0; m_rem = preset_secs(); end
        else begin
          m_el++;
          if (m_el == CLK_HZ) begin
            m_el = 0;
            m_secp = 1;
            m_alm_left--;
            m_blink = !m_blink;
            if (m_alm_left == 0) begin
              nm = AUTO ? 3 : 0;
              m_rem = preset_secs();
            end
          end
        end
      end
      default: nm = 0;
    endcase
    if (nm != m_mode) m_el = 0;
    m_mode = nm;
  endtask

  task automatic cyc(input int k);
    @(negedge mclk);
    key_code = 5'(k);
    @(posedge mclk);
    model_edge(k);
    #1;
    check_eq("status", 32'(status), 32'(m_mode));
    check_eq("rem", 32'({rem_h, rem_m, rem_s}), pack_rem(m_rem));
    check_eq("flags", 32'({sec_p, alarm, bitmap}), exp_flags());
  endtask

  task automatic press(input int k);
    cyc(k);
    cyc(0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, first, saved, k, hold, r;
    rst_n = 1'b0;
    key_code = 5'd0;
    model_reset();
    #12;
    check_eq("reset_outs", 32'({status, rem_h, rem_m, rem_s, sec_p, alarm, bitmap}), 32'h0000_0001);
    @(negedge mclk);
    rst_n = 1'b1;

    // START with zero preset is ignored
    pulses = 0;
    press(4);
    for (int i = 0; i < 8; i++) begin cyc(0); pulses += int'(sec_p); end
    check_eq("zero_start_st", 32'(status), 32'd0);
    check_eq("zero_start_secp", 32'(pulses), 32'd0);

    // Set preset 2:59
    press(1); press(2); press(2); press(1); press(3); press(1);
    check_eq("set_st", 32'(status), 32'd0);
    check_eq("set_rem", 32'({rem_h, rem_m, rem_s}), (32'd2 << 12) | (32'd59 << 6));

    // Held INC counts once
    press(5); press(1);
    for (int i = 0; i < 50; i++) cyc(2);
    cyc(0);
    check_eq("held_inc", 32'(rem_h), 32'd1);
    press(1); press(1);

    // Borrow chain from 1:00:00
    press(4);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin cyc(0); pulses += int'(sec_p); end
    check_eq("borrow_rem", 32'({rem_h, rem_m, rem_s}), (32'd59 << 6) | 32'd59);
    check_eq("borrow_pulses", 32'(pulses), 32'd1);
    for (int i = 0; i < 3599 * CLK_HZ; i++) cyc(0);
    check_eq("alarm_st", 32'(status), 32'd5);
    check_eq("alarm_out", 32'(alarm), 32'd1);
    check_eq("alarm_rem", 32'({rem_h, rem_m, rem_s}), 32'd0);
    check_eq("blink0", 32'(bitmap[15]), 32'd1);
    for (int i = 1; i <= 12; i++) begin
      cyc(0);
      if (i == 4) check_eq("blink1", 32'(bitmap[15]), 32'd0);
      if (i == 8) check_eq("blink2", 32'(bitmap[15]), 32'd1);
    end
    check_eq("alarm_end_st", 32'(status), AUTO ? 32'd3 : 32'd0);
    check_eq("alarm_end_rem", 32'({rem_h, rem_m, rem_s}), 32'd1 << 12);

    // START colliding with a tick pauses without decrementing
    if (m_mode != 3) press(4);
    for (int i = 0; i < 2 * CLK_HZ && m_el != CLK_HZ - 2; i++) cyc(0);
    saved = m_rem;
    cyc(4);
    cyc(0);
    check_eq("coll_st", 32'(status), 32'd4);
    check_eq("coll_rem", 32'({rem_h, rem_m, rem_s}), pack_rem(saved));
    check_eq("coll_secp", 32'(sec_p), 32'd0);
    press(4);
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(0);
      if (sec_p && first == 0) first = i;
    end
    check_eq("resume_lat", 32'(first), 32'(CLK_HZ));

    // Key-terminated alarm from 0:01
    press(5); press(5); press(1); press(1); press(2); press(1); press(4);
    for (int i = 0; i < 400 && m_mode != 5; i++) cyc(0);
    check_eq("short_alarm", 32'(status), 32'd5);
    press(9);
    check_eq("keyend_st", 32'(status), 32'd0);
    check_eq("keyend_rem", 32'({rem_h, rem_m, rem_s}), 32'd1 << 6);
    check_eq("keyend_alarm", 32'(alarm), 32'd0);

    // Asynchronous reset mid-RUN
    press(4);
    for (int i = 0; i < 6; i++) cyc(0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async", 32'({status, rem_h, rem_m, rem_s, sec_p, alarm, bitmap}), 32'h0000_0001);
    model_reset();
    key_code = 5'd0;
    @(negedge mclk);
    rst_n = 1'b1;

    // Random key traffic
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) k = 0;
      else if (r < 8) k = int'($urandom_range(1, 5));
      else k = int'($urandom_range(6, 16));
      hold = int'($urandom_range(1, 3));
      for (int j = 0; j < hold; j++) cyc(k);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
